// File: rtl/tally_reader.sv
// Post-poll result reader: scans every candidate slot of the ballot memory, streams one
// (candidate, count) record per slot, and latches winner / tie / no-votes / total summary.
module tally_reader #(
  parameter int NUM_CAND = 4,
  parameter int CAND_W   = 4,
  parameter int CNT_W    = 4,
  parameter int TOT_W    = 8
) (
  input  logic              clk,
  input  logic              initializer_n,
  input  logic              start,
  output logic              rd_en,
  output logic [CAND_W-1:0] rd_candidate,
  input  logic [CNT_W-1:0]  rd_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CAND_W-1:0] out_candidate,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy,
  output logic              voting_lock,
  output logic              done,
  output logic [CAND_W-1:0] winner,
  output logic [CNT_W-1:0]  winner_count,
  output logic              tie,
  output logic              no_votes,
  output logic [TOT_W-1:0]  total_votes
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAPT,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [CAND_W-1:0] LAST_IDX = CAND_W'(NUM_CAND - 1);

  state_t            state, state_nxt;
  logic [CAND_W-1:0] idx;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  max_q;
  logic [CAND_W-1:0] win_q;
  logic              tie_q;
  logic [TOT_W-1:0]  tot_q;
  logic [TOT_W:0]    tot_sum;
  logic [TOT_W-1:0]  tot_sat;

  // One extra carry bit detects overflow so the running total clamps at all-ones.
  assign tot_sum = {1'b0, tot_q} + (TOT_W + 1)'(rd_count);
  assign tot_sat = tot_sum[TOT_W] ? '1 : tot_sum[TOT_W-1:0];

  always_ff @(posedge clk or negedge initializer_n) begin
    if (!initializer_n) state <= S_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ADDR;
      S_ADDR:  state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_EMIT;
      S_EMIT:  if (out_ready) state_nxt = (idx == LAST_IDX) ? S_DONE : S_ADDR;
      S_DONE:  if (start) state_nxt = S_ADDR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The earliest slot to reach a new maximum keeps the win; later equal counts only flag a tie.
  always_ff @(posedge clk or negedge initializer_n) begin
    if (!initializer_n) begin
      idx   <= '0;
      cnt_q <= '0;
      max_q <= '0;
      win_q <= '0;
      tie_q <= 1'b0;
      tot_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx   <= '0;
            max_q <= '0;
            win_q <= '0;
            tie_q <= 1'b0;
            tot_q <= '0;
          end
        end
        S_CAPT: begin
          cnt_q <= rd_count;
          tot_q <= tot_sat;
          if (rd_count > max_q) begin
            max_q <= rd_count;
            win_q <= idx;
            tie_q <= 1'b0;
          end else if ((rd_count == max_q) && (rd_count != '0)) begin
            tie_q <= 1'b1;
          end
        end
        S_EMIT: begin
          if (out_ready && (idx != LAST_IDX)) idx <= idx + CAND_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rd_en         = (state == S_ADDR);
  assign rd_candidate  = idx;
  assign out_valid     = (state == S_EMIT);
  assign out_candidate = idx;
  assign out_count     = cnt_q;
  assign busy          = (state == S_ADDR) || (state == S_CAPT) || (state == S_EMIT);
  assign voting_lock   = busy;
  assign done          = (state == S_DONE);
  assign winner        = win_q;
  assign winner_count  = max_q;
  assign tie           = tie_q;
  assign no_votes      = done && (max_q == '0);
  assign total_votes   = tot_q;

endmodule

// File: tb/tb_tally_reader.sv
// Scoreboard bench for tally_reader: directed count sets, queued expected records,
// decoupled monitor, plus a narrow-total instance for saturation.
module tb_tally_reader;

  typedef struct {
    logic [3:0] cand;
    logic [3:0] cnt;
  } rec_t;

  logic       clk = 1'b0;
  logic       initializer_n = 1'b0;
  logic       start = 1'b0;
  logic       rd_en;
  logic [3:0] rd_candidate;
  logic [3:0] rd_count = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_candidate;
  logic [3:0] out_count;
  logic       busy, voting_lock, done, tie, no_votes;
  logic [3:0] winner, winner_count;
  logic [7:0] total_votes;

  logic       sat_start = 1'b0;
  logic       sat_rd_en, sat_out_valid, sat_busy, sat_lock, sat_done, sat_tie, sat_nv;
  logic [3:0] sat_rd_candidate, sat_out_candidate, sat_out_count, sat_winner, sat_wc;
  logic [3:0] sat_rd_count = 4'd0;
  logic [3:0] sat_total;

  logic [3:0] mem [4];
  rec_t       sb_q [$];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  tally_reader dut (
    .clk(clk), .initializer_n(initializer_n), .start(start),
    .rd_en(rd_en), .rd_candidate(rd_candidate), .rd_count(rd_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_candidate(out_candidate), .out_count(out_count),
    .busy(busy), .voting_lock(voting_lock), .done(done),
    .winner(winner), .winner_count(winner_count), .tie(tie),
    .no_votes(no_votes), .total_votes(total_votes)
  );

  tally_reader #(.TOT_W(4)) dut_sat (
    .clk(clk), .initializer_n(initializer_n), .start(sat_start),
    .rd_en(sat_rd_en), .rd_candidate(sat_rd_candidate), .rd_count(sat_rd_count),
    .out_valid(sat_out_valid), .out_ready(1'b1),
    .out_candidate(sat_out_candidate), .out_count(sat_out_count),
    .busy(sat_busy), .voting_lock(sat_lock), .done(sat_done),
    .winner(sat_winner), .winner_count(sat_wc), .tie(sat_tie),
    .no_votes(sat_nv), .total_votes(sat_total)
  );

  // Ballot memory model: count appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en) rd_count <= mem[rd_candidate[1:0]];
    if (sat_rd_en) sat_rd_count <= 4'd15;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted record must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (initializer_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_record", {28'd0, out_candidate}, 32'hFFFF);
      end else begin
        rec_t e;
        e = sb_q.pop_front();
        checkOutput("rec_cand", 32'(out_candidate), 32'(e.cand));
        checkOutput("rec_count", 32'(out_count), 32'(e.cnt));
      end
    end
  end

  function automatic logic [15:0] pack(input logic [3:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    if (!done) checkOutput(name, 32'(done), 32'd1);
  endtask

  task automatic checkSummary(input string tag, input logic [3:0] w, wc,
                              input logic t, nv, input logic [7:0] tot);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_winner"}, 32'(winner), 32'(w));
    checkOutput({tag, "_wcount"}, 32'(winner_count), 32'(wc));
    checkOutput({tag, "_tie"}, 32'(tie), 32'(t));
    checkOutput({tag, "_novotes"}, 32'(no_votes), 32'(nv));
    checkOutput({tag, "_total"}, 32'(total_votes), 32'(tot));
    checkOutput({tag, "_lock"}, 32'(voting_lock), 32'd0);
    checkOutput({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  // Loads memory, queues expected records, starts a scan; optional stall or stray start.
  task automatic applyStimulus(input logic [15:0] counts, input int stall_idx, input bit busy_start);
    int n;
    for (int i = 0; i < 4; i++) begin
      mem[i] = counts[4*i +: 4];
      sb_q.push_back('{cand: 4'(i), cnt: counts[4*i +: 4]});
    end
    out_ready = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_rd_en", 32'(rd_en), 32'd1);
    checkOutput("start_busy", 32'(busy), 32'd1);
    if (busy_start) begin
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (stall_idx >= 0) begin
      n = 0;
      while (!(rd_en && rd_candidate == 4'(stall_idx)) && n < 50) begin
        tick();
        n++;
      end
      out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
        tick();
        n++;
      end
      for (int k = 0; k < 5; k++) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_cand", 32'(out_candidate), 32'(stall_idx));
        checkOutput("stall_count", 32'(out_count), 32'(mem[stall_idx]));
        checkOutput("stall_no_rd", 32'(rd_en), 32'd0);
        tick();
      end
      out_ready = 1'b1;
    end
    waitDone("done_timeout");
  endtask

  initial begin
    int n;
    #2;
    checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_novotes", 32'(no_votes), 32'd0);
    checkOutput("rst_total", 32'(total_votes), 32'd0);
    tick();
    initializer_n = 1'b1;
    tick();

    applyStimulus(pack(4'd3, 4'd7, 4'd2, 4'd5), -1, 1'b0);
    checkSummary("t1", 4'd1, 4'd7, 1'b0, 1'b0, 8'd17);

    applyStimulus(pack(4'd4, 4'd6, 4'd6, 4'd1), -1, 1'b0);
    checkSummary("t2a", 4'd1, 4'd6, 1'b1, 1'b0, 8'd17);
    applyStimulus(pack(4'd6, 4'd6, 4'd0, 4'd0), -1, 1'b0);
    checkSummary("t2b", 4'd0, 4'd6, 1'b1, 1'b0, 8'd12);
    applyStimulus(pack(4'd5, 4'd5, 4'd8, 4'd0), -1, 1'b0);
    checkSummary("t2c", 4'd2, 4'd8, 1'b0, 1'b0, 8'd18);

    applyStimulus(pack(4'd0, 4'd0, 4'd0, 4'd0), -1, 1'b0);
    checkSummary("t3", 4'd0, 4'd0, 1'b0, 1'b1, 8'd0);

    applyStimulus(pack(4'd2, 4'd9, 4'd11, 4'd3), 2, 1'b0);
    checkSummary("t4", 4'd2, 4'd11, 1'b0, 1'b0, 8'd25);

    // Reset while record 1 is being presented.
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd3; mem[3] = 4'd4;
    sb_q.push_back('{cand: 4'd0, cnt: 4'd1});
    out_ready = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    checkOutput("t5_cand", 32'(out_candidate), 32'd1);
    initializer_n = 1'b0;
    #1;
    checkOutput("t5_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_lock", 32'(voting_lock), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_cand0", 32'(out_candidate), 32'd0);
    checkOutput("t5_count0", 32'(out_count), 32'd0);
    checkOutput("t5_total0", 32'(total_votes), 32'd0);
    checkOutput("t5_winner0", 32'(winner), 32'd0);
    checkOutput("t5_sb_empty", 32'(sb_q.size()), 32'd0);
    tick();
    initializer_n = 1'b1;
    tick();
    checkOutput("t5_idle", 32'(busy), 32'd0);
    applyStimulus(pack(4'd1, 4'd2, 4'd3, 4'd4), -1, 1'b0);
    checkSummary("t5", 4'd3, 4'd4, 1'b0, 1'b0, 8'd10);

    applyStimulus(pack(4'd9, 4'd1, 4'd9, 4'd9), -1, 1'b1);
    checkSummary("t6", 4'd0, 4'd9, 1'b1, 1'b0, 8'd28);
    for (int k = 0; k < 6; k++) tick();
    checkOutput("t6_done_held", 32'(done), 32'd1);
    checkOutput("t6_no_extra", 32'(out_valid), 32'd0);

    tick();
    sat_start = 1'b1;
    tick();
    sat_start = 1'b0;
    n = 0;
    while (!sat_done && n < 100) begin tick(); n++; end
    checkOutput("sat_done", 32'(sat_done), 32'd1);
    checkOutput("sat_total", 32'(sat_total), 32'd15);
    checkOutput("sat_winner", 32'(sat_winner), 32'd0);
    checkOutput("sat_wcount", 32'(sat_wc), 32'd15);
    checkOutput("sat_tie", 32'(sat_tie), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
